// File: rtl/video_pattern_gen.sv
// video_pattern_gen: 720p test-pattern source with frame-synchronous
// mode switching, auto-cycling, moving box and a two-stage pixel pipeline.
module video_pattern_gen #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int VS_POL      = 1,
    parameter int AUTO_FRAMES = 120,
    parameter int BOX_SIZE    = 64,
    parameter int BOX_STEP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_next,
    input  logic        auto_en,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [10:0] active_x,
    input  logic [10:0] active_y,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b,
    output logic [1:0]  mode,
    output logic [15:0] frame_cnt
);

    localparam int ACW = $clog2(AUTO_FRAMES) + 1;
    localparam logic VPOL = VS_POL[0];
    localparam logic [11:0] BW   = 12'(H_ACTIVE / 8);
    localparam logic [11:0] LX12 = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] LY12 = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] LX   = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] LY   = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] ST12 = 12'(BOX_STEP);
    localparam logic [10:0] ST   = 11'(BOX_STEP);
    localparam logic [11:0] BS12 = 12'(BOX_SIZE);

    logic            r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
    logic [23:0]     r_rgb1, r_rgb2;
    logic            r_armed, r_pend;
    logic [1:0]      r_mode;
    logic [ACW-1:0]  r_acnt;
    logic [15:0]     r_fc;
    logic [10:0]     r_bx, r_by;
    logic            r_bxneg, r_byneg;

    logic            w_fs, w_adv;
    logic [11:0]     w_x, w_y;
    logic [23:0]     w_col;
    logic [10:0]     w_bx_n, w_by_n;
    logic            w_bxneg_n, w_byneg_n;

    assign w_x   = {1'b0, active_x};
    assign w_y   = {1'b0, active_y};
    // r_armed keeps the stale reset value of r_vs1 from faking an edge
    assign w_fs  = r_armed & (r_vs1 != VPOL) & (vs_i == VPOL);
    assign w_adv = w_fs & (r_pend | mode_next |
                   (auto_en & (r_acnt == ACW'(AUTO_FRAMES - 1))));

    // Pattern colour for the current pixel, using the displayed mode
    always_comb begin
        w_col = 24'h000000;
        case (r_mode)
            2'd0: begin
                if (w_x < BW)            w_col = 24'hFFFFFF;
                else if (w_x < BW * 2)   w_col = 24'hFFFF00;
                else if (w_x < BW * 3)   w_col = 24'h00FFFF;
                else if (w_x < BW * 4)   w_col = 24'h00FF00;
                else if (w_x < BW * 5)   w_col = 24'hFF00FF;
                else if (w_x < BW * 6)   w_col = 24'hFF0000;
                else if (w_x < BW * 7)   w_col = 24'h0000FF;
                else                     w_col = 24'h000000;
            end
            2'd1: begin
                if (active_x[5:0] == 6'd0 || active_y[5:0] == 6'd0 ||
                    w_x == 12'(H_ACTIVE - 1) ||
                    w_y == 12'(V_ACTIVE - 1))
                    w_col = 24'hFFFFFF;
            end
            2'd2: begin
                w_col = {active_x[10:3], active_y[9:2],
                         8'((w_x + w_y) >> 3)};
            end
            default: begin
                if (w_x >= {1'b0, r_bx} && w_x < {1'b0, r_bx} + BS12 &&
                    w_y >= {1'b0, r_by} && w_y < {1'b0, r_by} + BS12)
                    w_col = 24'hFF0000;
                else
                    w_col = 24'h000040;
            end
        endcase
    end

    // Next box position: bounce each axis between 0 and its limit
    always_comb begin
        w_bx_n    = r_bx;
        w_bxneg_n = r_bxneg;
        w_by_n    = r_by;
        w_byneg_n = r_byneg;
        if (!r_bxneg) begin
            if ({1'b0, r_bx} + ST12 >= LX12) begin
                w_bx_n    = LX;
                w_bxneg_n = 1'b1;
            end else begin
                w_bx_n = r_bx + ST;
            end
        end else begin
            if ({1'b0, r_bx} <= ST12) begin
                w_bx_n    = 11'd0;
                w_bxneg_n = 1'b0;
            end else begin
                w_bx_n = r_bx - ST;
            end
        end
        if (!r_byneg) begin
            if ({1'b0, r_by} + ST12 >= LY12) begin
                w_by_n    = LY;
                w_byneg_n = 1'b1;
            end else begin
                w_by_n = r_by + ST;
            end
        end else begin
            if ({1'b0, r_by} <= ST12) begin
                w_by_n    = 11'd0;
                w_byneg_n = 1'b0;
            end else begin
                w_by_n = r_by - ST;
            end
        end
    end

    // Two-stage pixel pipeline with matched sync delay
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_de1  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_de2  <= 1'b0;
            r_rgb1 <= 24'h0;
            r_rgb2 <= 24'h0;
        end else begin
            r_hs1  <= hs_i;
            r_vs1  <= vs_i;
            r_de1  <= de_i;
            r_rgb1 <= w_col;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_de2  <= r_de1;
            r_rgb2 <= r_de1 ? r_rgb1 : 24'h0;
        end
    end

    // Mode, request, auto-cycle and frame counter, all frame-synchronous
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_pend  <= 1'b0;
            r_mode  <= 2'd0;
            r_acnt  <= '0;
            r_fc    <= 16'd0;
        end else begin
            r_armed <= 1'b1;
            if (w_fs) begin
                r_fc <= r_fc + 16'd1;
                if (w_adv) begin
                    r_mode <= r_mode + 2'd1;
                    r_pend <= 1'b0;
                    r_acnt <= '0;
                end else begin
                    r_acnt <= auto_en ? r_acnt + ACW'(1) : '0;
                end
            end else begin
                if (mode_next) r_pend <= 1'b1;
                if (!auto_en)  r_acnt <= '0;
            end
        end
    end

    // Box position advances once per frame in every mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bx    <= 11'd0;
            r_by    <= 11'd0;
            r_bxneg <= 1'b0;
            r_byneg <= 1'b0;
        end else if (w_fs) begin
            r_bx    <= w_bx_n;
            r_by    <= w_by_n;
            r_bxneg <= w_bxneg_n;
            r_byneg <= w_byneg_n;
        end
    end

    assign hs_o      = r_hs2;
    assign vs_o      = r_vs2;
    assign de_o      = r_de2;
    assign rgb_r     = r_rgb2[23:16];
    assign rgb_g     = r_rgb2[15:8];
    assign rgb_b     = r_rgb2[7:0];
    assign mode      = r_mode;
    assign frame_cnt = r_fc;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed + random frames against a behavioural
// model of pattern rules, mode control and box motion.
module tb_video_pattern_gen;

    localparam int AF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_next, auto_en;
    logic        hs_i, vs_i, de_i;
    logic [10:0] active_x, active_y;
    logic        hs_o, vs_o, de_o;
    logic [7:0]  rgb_r, rgb_g, rgb_b;
    logic [1:0]  mode;
    logic [15:0] frame_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_mode, m_pend, m_acnt, m_fc, m_bx, m_by;
    bit m_xneg, m_yneg, m_armed, m_vprev;
    logic [26:0] q[$];

    always #5 clk = ~clk;

    video_pattern_gen #(.AUTO_FRAMES(AF)) dut (
        .clk(clk), .rst_n(rst_n), .mode_next(mode_next),
        .auto_en(auto_en), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
        .active_x(active_x), .active_y(active_y),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .mode(mode), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] colour(input int x, input int y);
        case (m_mode)
            0: case (x / 160)
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            1: return (x % 64 == 0 || y % 64 == 0 || x == 1279 ||
                       y == 719) ? 24'hFFFFFF : 24'h000000;
            2: return {8'((x >> 3) & 255), 8'((y >> 2) & 255),
                       8'(((x + y) >> 3) & 255)};
            default: return (x >= m_bx && x < m_bx + 64 &&
                             y >= m_by && y < m_by + 64) ?
                            24'hFF0000 : 24'h000040;
        endcase
    endfunction

    task automatic axis(inout int p, inout bit neg, input int lim);
        if (!neg) begin
            if (p + 2 >= lim) begin p = lim; neg = 1; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; neg = 0; end
            else p = p - 2;
        end
    endtask

    task automatic tick(input logic h, input logic v, input logic d,
                        input int x, input int y, input logic mn);
        logic [26:0] e, expo;
        bit fs;
        @(negedge clk);
        hs_i = h; vs_i = v; de_i = d; mode_next = mn;
        active_x = 11'(x); active_y = 11'(y);
        e = {h, v, d, d ? colour(x, y) : 24'h0};
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_pend = 0; m_acnt = 0; m_fc = 0;
            m_bx = 0; m_by = 0; m_xneg = 0; m_yneg = 0;
            m_armed = 0; m_vprev = 0;
            q.delete();
            q.push_back(27'h0);
            expo = 27'h0;
        end else begin
            q.push_back(e);
            expo = q.pop_front();
            fs = m_armed && !m_vprev && v;
            m_vprev = v;
            m_armed = 1;
            if (fs) begin
                if (m_pend != 0 || mn || (auto_en && m_acnt == AF - 1)) begin
                    m_mode = (m_mode + 1) % 4;
                    m_pend = 0;
                    m_acnt = 0;
                end else begin
                    m_acnt = auto_en ? m_acnt + 1 : 0;
                end
                m_fc = (m_fc + 1) % 65536;
                axis(m_bx, m_xneg, 1216);
                axis(m_by, m_yneg, 656);
            end else begin
                if (mn) m_pend = 1;
                if (!auto_en) m_acnt = 0;
            end
        end
        #1;
        chk("video", {hs_o, vs_o, de_o, rgb_r, rgb_g, rgb_b}, 32'(expo));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    endtask

    function automatic int rx();
        return $urandom_range(0, 1279);
    endfunction

    function automatic int ry();
        return $urandom_range(0, 719);
    endfunction

    task automatic vsync(input logic mn);
        tick(0, 1, 0, rx(), ry(), mn);
        tick(0, 1, 0, rx(), ry(), 0);
        tick(1, 0, 0, rx(), ry(), 0);
    endtask

    task automatic frame(input int npix, input logic mn_fs,
                         input int mn_pix);
        vsync(mn_fs);
        for (int i = 0; i < npix; i++) begin
            tick(0, 0, 1, rx(), ry(), i == mn_pix);
            if ($urandom_range(0, 2) == 0)
                tick(1'($urandom_range(0, 1)), 0, 0, rx(), ry(), 0);
        end
    endtask

    task automatic pix_lit(input int x, input int y, input logic [23:0] exp);
        tick(0, 0, 1, x, y, 0);
        tick(0, 0, 0, rx(), ry(), 0);
        chk("literal_rgb", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, exp});
    endtask

    task automatic box_probe();
        tick(0, 0, 1, m_bx, m_by, 0);
        tick(0, 0, 1, m_bx + 63, m_by + 63, 0);
        if (m_bx + 64 <= 1279) tick(0, 0, 1, m_bx + 64, m_by, 0);
        if (m_by > 0) tick(0, 0, 1, m_bx, m_by - 1, 0);
    endtask

    int auto_exp [8] = '{0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        rst_n = 0; auto_en = 0; mode_next = 0;
        hs_i = 0; vs_i = 0; de_i = 0; active_x = 0; active_y = 0;
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        rst_n = 1;
        tick(0, 0, 0, 0, 0, 0);

        vsync(0);
        pix_lit(0, 10, 24'hFFFFFF);
        pix_lit(159, 10, 24'hFFFFFF);
        pix_lit(160, 10, 24'hFFFF00);
        pix_lit(1279, 10, 24'h000000);
        for (int i = 0; i < 12; i++) tick(1'($urandom_range(0, 1)),
            0, 1'($urandom_range(0, 1)), rx(), ry(), 0);

        vsync(0);
        tick(0, 0, 1, 500, 300, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, rx(), 301, 0);
        chk("mode_hold", 32'(mode), 32'd0);

        vsync(0);
        chk("mode_grid", 32'(mode), 32'd1);
        pix_lit(64, 5, 24'hFFFFFF);
        pix_lit(65, 5, 24'h000000);
        pix_lit(1279, 100, 24'hFFFFFF);
        tick(0, 0, 1, rx(), ry(), 1);

        vsync(0);
        chk("mode_grad", 32'(mode), 32'd2);
        pix_lit(1279, 719, 24'h9FB3F9);
        for (int i = 0; i < 6; i++) tick(0, 0, 1, rx(), ry(), 0);

        vsync(0);
        chk("fc_before_rst", 32'(frame_cnt), 32'd5);
        tick(0, 0, 1, rx(), ry(), 0);
        rst_n = 0;
        tick(0, 0, 1, rx(), ry(), 0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_rgb", {8'h0, rgb_r, rgb_g, rgb_b}, 32'd0);
        tick(0, 0, 1, rx(), ry(), 0);
        tick(0, 0, 1, rx(), ry(), 0);
        rst_n = 1;
        tick(0, 1, 0, rx(), ry(), 0);
        tick(0, 1, 0, rx(), ry(), 0);
        tick(0, 0, 0, rx(), ry(), 0);
        chk("no_fs_after_rst", 32'(frame_cnt), 32'd0);

        for (int k = 0; k < 3; k++) frame(4, 0, 2);
        vsync(0);
        chk("mode_box", 32'(mode), 32'd3);

        for (int f = 0; f < 700; f++) begin
            frame(2, 0, -1);
            box_probe();
        end

        auto_en = 1;
        frame(2, 0, -1);
        frame(2, 1, -1);
        chk("auto_plus_req", 32'(mode), 32'd0);
        for (int f = 0; f < 8; f++) begin
            frame(2, 0, -1);
            chk("auto_seq", 32'(mode), 32'(auto_exp[f]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Test-pattern source that sits directly downstream of the 720p timing generator and feeds the HDMI/TMDS encoder. It consumes hs/vs/de plus active_x/active_y and produces 24-bit RGB with sync/de realigned to the pixel pipeline. It offers four selectable patterns with frame-synchronous switching, optional auto-cycling, and a frame counter.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
VS_POL, 1, vs_i active level; frame start = vs_i entering this level
AUTO_FRAMES, 120, frames per mode when auto-cycling (>=1)
BOX_SIZE, 64, moving-box edge length in pixels
BOX_STEP, 2, box displacement per frame per axis

Ports:
clk  in  1  pixel clock (74.25 MHz for 720p)
rst_n  in  1  reset; synchronous and active-low
mode_next  in  1  single-cycle pulse requesting the next pattern
auto_en  in  1  1 = advance pattern every AUTO_FRAMES frames
hs_i  in  1  horizontal sync from timing generator
vs_i  in  1  vertical sync from timing generator
de_i  in  1  video valid from timing generator
active_x  in  11  pixel x, 0..H_ACTIVE-1, valid while de_i=1
active_y  in  11  pixel y, 0..V_ACTIVE-1, valid while de_i=1
hs_o  out  1  hs_i delayed 2 cycles
vs_o  out  1  vs_i delayed 2 cycles
de_o  out  1  de_i delayed 2 cycles
rgb_r  out  8  red
rgb_g  out  8  green
rgb_b  out  8  blue
mode  out  2  pattern currently displayed
frame_cnt  out  16  frames since reset, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, pipeline registers 0, pending request cleared, box at (0,0) moving +x/+y, auto counter 0.
- Frame start (fs): one-cycle internal strobe when registered vs_i_d != VS_POL and vs_i == VS_POL. No fs on the first cycle after reset.
- Pipeline: stage 1 registers the pattern colour from (mode, active_x, active_y, box state); stage 2 registers rgb and gates it to 0 when the delayed de is 0. Total latency 2 cycles; hs/vs/de pass through a matched 2-deep delay.
- Mode control:
  - mode_next pulse sets pending=1 at any time.
  - At fs: if pending or (auto_en and auto_cnt==AUTO_FRAMES-1), mode<=mode+1 (2-bit wrap 3->0), pending<=0, auto_cnt<=0; otherwise auto_cnt increments while auto_en=1 and holds at 0 while auto_en=0.
  - Pending and auto expiry at the same fs advance the mode by exactly one.
  - mode_next in the same cycle as fs is applied at that fs.
  - Mode never changes mid-frame.
- frame_cnt increments at every fs.
- Pattern 0, colour bars: 8 bars of H_ACTIVE/8 px, selected by comparators (no divider), in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Pattern 1, grid: white where active_x[5:0]==0, active_y[5:0]==0, active_x==H_ACTIVE-1 or active_y==V_ACTIVE-1; else black.
- Pattern 2, gradient: R=active_x[10:3], G=active_y[9:2], B=(active_x+active_y) 12-bit sum bits [10:3].
- Pattern 3, moving box: red FF0000 where bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE; else 000040.
- Box update at every fs regardless of mode. Per axis, with limit L = H_ACTIVE-BOX_SIZE (x) or V_ACTIVE-BOX_SIZE (y):
  - Moving +: if pos+BOX_STEP >= L, then pos<=L and dir<=-; else pos<=pos+BOX_STEP.
  - Moving -: if pos <= BOX_STEP, then pos<=0 and dir<=+; else pos<=pos-BOX_STEP.
- Reset mid-frame: outputs go to 0 on the next edge. Normal output resumes with the next pixel after rst_n returns to 1, in mode 0.

Test Plan:
- Reset, mode 0, run one frame -> at de_o=1 with x=0 rgb=FFFFFF; x=159 FFFFFF; x=160 FFFF00; x=1279 000000. rgb=0 whenever de_o=0. hs_o/vs_o/de_o equal inputs delayed exactly 2 cycles.
- Pulse mode_next at line 300 of frame N -> mode stays 0 through frame N, becomes 1 at the next fs. Grid: (64,5)=FFFFFF, (65,5)=000000, (1279,100)=FFFFFF.
- AUTO_FRAMES=2, auto_en=1, plus mode_next pulsed on the fs cycle where auto also expires -> mode advances by 1 only. Thereafter mode changes every 2 frames, sequence 0,1,2,3,0.
- Mode 2, pixel (1279,719) -> rgb = 9F,B3,F9 (sum 1998 = 0x7CE, bits[10:3] = 0xF9).
- Mode 3, run 700 frames -> bx rises by 2 per frame to 1216, clamps there, reverses direction. by bounces at 656 and at 0. Box pixels FF0000, background 000040.
- Assert rst_n=0 for 3 cycles mid-line in mode 2 with frame_cnt=5 -> all outputs 0 on the next edge, frame_cnt=0, mode=0, box at (0,0).
